div_unit: RTL and testbench

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits in the EX stage beside the ALU and is the responder side of the divide stall protocol. The stall controller pulses `start`, holds the pipeline while `busy` is high, and captures `result` on `done`. It replaces a fixed-latency divider core, so completion is signalled by the divider itself rather than by a fixed count.

---
 rtl/div_unit.sv | 121 ++++++++++++
 tb/tb_div_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divider; `DIV_FAST_CORNER_EN finishes div-by-zero/overflow in one cycle
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, cval_q, cval_d, result_q, result_d;
  logic op1_q, op1_d, neg_q, neg_d, sgn_q, sgn_d, cor_q, cor_d, busy_q, busy_d, done_q, done_d;
  logic sgn_op, a_neg, b_neg, div0, ovf, corner, accept;
  logic [XLEN-1:0] a_mag, b_mag, cval, rem_n, quo_n, q_fix, r_fix, fix;
  logic [XLEN:0] sh, trial;
  assign sgn_op = ~op[0];
  assign a_neg  = sgn_op & dividend[XLEN-1];
  assign b_neg  = sgn_op & divisor[XLEN-1];
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor : divisor;
  assign div0   = divisor == '0;
  assign ovf    = sgn_op & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor);
  assign corner = div0 | ovf;
  assign cval   = div0 ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
  assign accept = start & ~flush & (state_q != CALC);
  // Trial subtraction at XLEN+1 bits: its MSB is the borrow that decides the quotient bit
  assign sh     = {rem_q, quo_q[XLEN-1]};
  assign trial  = sh - {1'b0, dvs_q};
  assign rem_n  = trial[XLEN] ? sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_n  = {quo_q[XLEN-2:0], ~trial[XLEN]};
  assign q_fix  = neg_q ? -quo_n : quo_n;
  assign r_fix  = sgn_q ? -rem_n : rem_n;
  assign fix    = cor_q ? cval_q : (op1_q ? r_fix : q_fix);
  always_comb begin
    state_d  = (state_q == CALC) ? CALC : IDLE;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cval_d   = cval_q;
    result_d = result_q;
    op1_d    = op1_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    cor_d    = cor_q;
    if (accept) begin
      op1_d  = op[1];
      neg_d  = a_neg ^ b_neg;
      sgn_d  = a_neg;
      cor_d  = corner;
      cval_d = cval;
      rem_d  = '0;
      quo_d  = a_mag;
      dvs_d  = b_mag;
      cnt_d  = CW'(XLEN-1);
`ifdef DIV_FAST_CORNER_EN
      state_d  = corner ? DONE : CALC;
      result_d = corner ? cval : result_q;
`else
      state_d  = CALC;
`endif
    end else if (state_q == CALC) begin
      if (flush) begin
        state_d = IDLE;
      end else begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = fix;
        end
      end
    end
    busy_d = state_d == CALC;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cval_q   <= '0;
      result_q <= '0;
      op1_q    <= 1'b0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      cor_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cval_q   <= cval_d;
      result_q <= result_d;
      op1_q    <= op1_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
      cor_q    <= cor_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit covering signed/unsigned ops, corners, back-to-back, flush and reset
module tb_div_unit;
`ifdef DIV_FAST_CORNER_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, aresetn = 1'b0, start = 1'b0, flush = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] dividend = '0, divisor = '0;
  logic busy, done;
  logic [31:0] result;
  typedef struct {
    logic [31:0] res;
    int due;
    int bsy;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0, bcnt = 0, ndone = 0, t_acc = 0;
  logic [31:0] last_exp = '0;
  div_unit #(.XLEN(32)) dut (
    .clk(clk), .aresetn(aresetn), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .flush(flush), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
    case (o)
      2'd0: return $signed(a) / $signed(b);
      2'd1: return a / b;
      2'd2: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (done) begin
      ndone++;
      check("busy_in_done", 32'(busy), 32'd0);
      if (sb.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", 32'(cyc), 32'(e.due));
        check("busy_cycles", 32'(bcnt), 32'(e.bsy));
      end
      bcnt = 0;
    end else bcnt = busy ? bcnt + 1 : 0;
  end
  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    bit fc;
    exp_t e;
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    t_acc = cyc + 1;
    fc = FAST && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    if (push) begin
      e.res = exp; e.due = t_acc + (fc ? 0 : 32); e.bsy = fc ? 0 : 32;
      sb.push_back(e);
      last_exp = exp;
    end
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end
  initial begin
    exp_t e;
    int nd0;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    aresetn = 1'b1;
    drive(2'd0, 32'd100, 32'd7, 32'd14, 1'b1); drain();
    drive(2'd2, 32'd100, 32'd7, 32'd2, 1'b1); drain();
    drive(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1); drain();
    drive(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1); drain();
    drive(2'd1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b1); drain();
    drive(2'd3, 32'hFFFF_FFF9, 32'd2, 32'd1, 1'b1); drain();
    drive(2'd0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1); drain();
    drive(2'd1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1); drain();
    drive(2'd2, 32'h1234, 32'd0, 32'h1234, 1'b1); drain();
    drive(2'd3, 32'h1234, 32'd0, 32'h1234, 1'b1); drain();
    drive(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); drain();
    drive(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1); drain();
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      drive(ro, ra, rb, model_res(ro, ra, rb), 1'b1); drain();
    end
    // start held high: second request is taken in the first DONE cycle
    @(negedge clk);
    op = 2'd0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    t_acc = cyc + 1;
    e.res = 32'd14; e.due = t_acc + 32; e.bsy = 32; sb.push_back(e);
    e.res = 32'd142; e.due = t_acc + 65; e.bsy = 32; sb.push_back(e);
    last_exp = 32'd142;
    repeat (10) @(negedge clk);
    op = 2'd1; dividend = 32'd1000;
    repeat (24) @(negedge clk);
    start = 1'b0;
    drain();
    drive(2'd0, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (4) @(negedge clk);
    op = 2'd3; dividend = 32'd5; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    drive(2'd1, 32'hFFFF, 32'd3, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    check("busy_pre_flush", 32'(busy), 32'd1);
    flush = 1'b1;
    nd0 = ndone;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_no_done", 32'(ndone), 32'(nd0));
    check("flush_result", result, last_exp);
    @(negedge clk);
    op = 2'd1; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_start_no_done", 32'(ndone), 32'(nd0));
    drive(2'd0, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (19) @(negedge clk);
    check("busy_pre_reset", 32'(busy), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_done", 32'(ndone), 32'(nd0));
    drive(2'd1, 32'd9, 32'd3, 32'd3, 1'b1); drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
